// File: rtl/tri_link_pkg.sv
// Shared types and constants for the tristate link receiver.
package tri_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_GAP    = 3'd4,
        ST_ACK    = 3'd5,
        ST_WAITHI = 3'd6
    } state_t;

    localparam int unsigned CLKS_PER_BIT_DEF = 16;
    localparam int unsigned FRAME_W          = 8;
    localparam logic        ACK_LEVEL        = 1'b0;

endpackage

// File: rtl/tri_sync.sv
// Two-flop pad synchronizer; resets to the idle (high) line level.
module tri_sync (
    input  logic clk,
    input  logic resetn,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    // Shift the raw pad value through two flops
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/tri_link_rx.sv
// Receive side of the single-wire tristate link: deserializes one frame,
// checks the stop bit, then turns the line around for a one-bit-time ACK.
module tri_link_rx
    import tri_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               pad_in,
    output logic               pad_out,
    output logic               pad_oe,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               frame_err,
    output logic               overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(FRAME_W);

    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_W - 1);

    logic               w_s_in;
    logic               r_s_prev;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [FRAME_W-1:0] r_shift;
    logic [FRAME_W-1:0] w_shift_nxt;
    logic               w_cnt_zero;
    logic               w_load;
    logic               w_ovr;
    logic               w_ferr;

    logic [FRAME_W-1:0] r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_err;
    logic               r_overrun;
    logic               r_pad_oe;
    logic               r_pad_out;

    tri_sync u_sync (
        .clk    (clk),
        .resetn (resetn),
        .i_d    (pad_in),
        .o_q    (w_s_in)
    );

    assign w_cnt_zero = (r_cnt == '0);

    // FSM state, bit timer, bit index, shift register and edge-detect history
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_s_prev <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_s_prev <= w_s_in;
        end
    end

    // Next-state, timer reloads and one-shot frame decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_ovr       = 1'b0;
        w_ferr      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_s_in && r_s_prev) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = CNT_HALF;
                end
            end
            ST_START: begin
                if (w_cnt_zero) begin
                    if (!w_s_in) begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = CNT_BIT;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (w_cnt_zero) begin
                    w_shift_nxt = {w_s_in, r_shift[FRAME_W-1:1]};
                    w_cnt_nxt   = CNT_BIT;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (w_cnt_zero) begin
                    if (!w_s_in) begin
                        w_ferr      = 1'b1;
                        w_state_nxt = ST_WAITHI;
                    end else if (!r_rx_valid || rx_ready) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_GAP;
                        w_cnt_nxt   = CNT_BIT;
                    end else begin
                        w_ovr       = 1'b1;
                        w_state_nxt = ST_WAITHI;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_ACK;
                    w_cnt_nxt   = CNT_BIT;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_ACK: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_WAITHI;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_WAITHI: begin
                // Our own ACK echoes back through the synchronizer; wait it out
                if (w_s_in) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs: holding register, status pulses and pad controls
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_pad_oe    <= 1'b0;
            r_pad_out   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= w_ovr;
            r_pad_oe    <= (w_state_nxt == ST_ACK);
            r_pad_out   <= ACK_LEVEL;
            if (w_load) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign pad_oe    = r_pad_oe;
    assign pad_out   = r_pad_out;

endmodule

// File: tb/tb_tri_link_rx.sv
// Directed bench for tri_link_rx with CLKS_PER_BIT = 8 and a modelled pad.
module tb_tri_link_rx;

    localparam int unsigned CLKS = 8;

    logic       clk;
    logic       resetn;
    logic       r_line;
    logic       w_pad_in;
    logic       pad_out;
    logic       pad_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int n_vec = 0;
    int n_err = 0;

    // Pad: our driver wins when enabled, otherwise the peer/pull-up level
    assign w_pad_in = pad_oe ? pad_out : r_line;

    tri_link_rx #(.CLKS_PER_BIT(CLKS)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .pad_in    (w_pad_in),
        .pad_out   (pad_out),
        .pad_oe    (pad_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one frame; returns one cycle after the stop-bit sample edge
    task automatic send(input logic [7:0] data, input logic stop, input logic rdy_stop);
        logic saved;
        r_line = 1'b0;
        tick(CLKS);
        for (int k = 0; k < 8; k++) begin
            r_line = data[k];
            tick(CLKS);
        end
        r_line = stop;
        tick(CLKS - 2);
        saved = rx_ready;
        if (rdy_stop) rx_ready = 1'b1;
        tick(1);
        rx_ready = saved;
    endtask

    // Release the line and check pulse widths and ACK window after a frame
    task automatic after_stop(input string tag, input logic exp_ack, input logic exp_valid);
        tick(1);
        r_line = 1'b1;
        chk({tag, "_valid_next"}, rx_valid, exp_valid);
        chk({tag, "_pulses_clear"}, {frame_err, overrun}, 8'h00);
        tick(CLKS - 2);
        chk({tag, "_oe_gap"}, pad_oe, 1'b0);
        tick(1);
        chk({tag, "_oe_rise"}, pad_oe, exp_ack);
        chk({tag, "_pad_out"}, pad_out, 1'b0);
        tick(CLKS - 1);
        chk({tag, "_oe_hold"}, pad_oe, exp_ack);
        tick(1);
        chk({tag, "_oe_fall"}, pad_oe, 1'b0);
        tick(CLKS);
    endtask

    initial begin
        resetn   = 1'b0;
        r_line   = 1'b1;
        rx_ready = 1'b1;
        tick(2);
        chk("rst_pad_out",   pad_out,   1'b0);
        chk("rst_pad_oe",    pad_oe,    1'b0);
        chk("rst_rx_data",   rx_data,   8'h00);
        chk("rst_rx_valid",  rx_valid,  1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_overrun",   overrun,   1'b0);
        resetn = 1'b1;
        tick(5);

        // Good frame, consumer always ready
        send(8'hA5, 1'b1, 1'b0);
        chk("a5_valid", rx_valid, 1'b1);
        chk("a5_data",  rx_data,  8'hA5);
        chk("a5_err",   {frame_err, overrun}, 8'h00);
        after_stop("a5", 1'b1, 1'b0);

        // Byte held while consumer stalls
        rx_ready = 1'b0;
        send(8'h3C, 1'b1, 1'b0);
        chk("3c_valid", rx_valid, 1'b1);
        chk("3c_data",  rx_data,  8'h3C);
        after_stop("3c", 1'b1, 1'b1);

        // Second frame with register full: overrun, no ACK
        send(8'h81, 1'b1, 1'b0);
        chk("81_overrun", overrun,   1'b1);
        chk("81_ferr",    frame_err, 1'b0);
        chk("81_valid",   rx_valid,  1'b1);
        chk("81_data",    rx_data,   8'h3C);
        after_stop("81", 1'b0, 1'b1);
        chk("81_data_held", rx_data, 8'h3C);

        // Ready exactly on the stop-sample cycle: drain and reload together
        send(8'h5A, 1'b1, 1'b1);
        chk("5a_overrun", overrun,  1'b0);
        chk("5a_valid",   rx_valid, 1'b1);
        chk("5a_data",    rx_data,  8'h5A);
        after_stop("5a", 1'b1, 1'b1);
        rx_ready = 1'b1;
        tick(1);
        chk("5a_drained", rx_valid, 1'b0);

        // Stop bit forced low
        send(8'h55, 1'b0, 1'b0);
        chk("55_ferr",  frame_err, 1'b1);
        chk("55_ovr",   overrun,   1'b0);
        chk("55_valid", rx_valid,  1'b0);
        after_stop("55", 1'b0, 1'b0);

        // Short low glitch on the idle line must not produce a frame
        r_line = 1'b0;
        tick(3);
        r_line = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("glitch_quiet", {4'h0, pad_oe, rx_valid, frame_err, overrun}, 8'h00);
            tick(1);
        end
        send(8'h96, 1'b1, 1'b0);
        chk("96_valid", rx_valid, 1'b1);
        chk("96_data",  rx_data,  8'h96);
        after_stop("96", 1'b1, 1'b0);

        // Reset in the middle of the ACK window
        send(8'hC3, 1'b1, 1'b0);
        chk("c3_data", rx_data, 8'hC3);
        tick(1);
        r_line = 1'b1;
        tick(CLKS - 1);
        chk("c3_oe_on", pad_oe, 1'b1);
        tick(3);
        resetn = 1'b0;
        #1;
        chk("c3_rst_oe",    pad_oe,   1'b0);
        chk("c3_rst_valid", rx_valid, 1'b0);
        chk("c3_rst_data",  rx_data,  8'h00);
        tick(3);
        resetn = 1'b1;
        tick(5);

        send(8'h0F, 1'b1, 1'b0);
        chk("0f_valid", rx_valid, 1'b1);
        chk("0f_data",  rx_data,  8'h0F);
        after_stop("0f", 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
